mat_mult_seq: RTL and testbench

- Sequential N x N integer matrix multiplier. Computes C = A * B using one multiply-accumulate per clock.
- Serves as the reverse-direction companion to the combinational RREF inverter. Multiplying the inverter's output by the original matrix rebuilds the product, which lets us check that the result is the identity on-chip.
- Sits after the inverter. Uses a start/busy/done handshake and raises an identity flag when the product is the identity matrix.

---
 rtl/mat_pkg.sv | 18 +
 rtl/mat_mult_seq_mac_unit.sv | 30 +++
 rtl/mat_mult_seq.sv | 116 +++++++++++
 tb/tb_mat_mult_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_pkg.sv
// Shared definitions for the sequential matrix multiplier: default sizes,
// controller states and the flat-vector element offset helper.
package mat_pkg;
  localparam int N_DEFAULT = 5;
  localparam int W_DEFAULT = 32;
  localparam int IDXW      = $clog2(N_DEFAULT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit offset of element (r,c) in a row-major flattened N x N matrix.
  function automatic int flat_off(input int r, input int c, input int n, input int w);
    return (r * n + c) * w;
  endfunction
endpackage

// File: rtl/mat_mult_seq_mac_unit.sv
// Multiply-accumulate slice: W-bit truncating multiply, registered accumulator,
// and a combinational acc+prod used for the final element write.
module mac_unit #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);
  logic [W-1:0] acc;
  logic [W-1:0] prod;

  // W-bit result context keeps only the low W bits (modulo 2^W).
  assign prod = a * b;
  assign sum  = acc + prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end
endmodule

// File: rtl/mat_mult_seq.sv
// Sequential N x N matrix multiplier (C = A * B), one MAC per cycle, with a
// start/busy/done handshake and an identity-product flag.
module mat_mult_seq
  import mat_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int W = W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N*N*W-1:0] a_flat,
  input  logic [N*N*W-1:0] b_flat,
  output logic             busy,
  output logic             done,
  output logic [N*N*W-1:0] c_flat,
  output logic             is_ident,
  output logic [1:0]       dbg_state
);
  localparam int IW = (N == N_DEFAULT) ? IDXW : $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  // Handshake: start is sampled only in IDLE/DONE; done pulses for one cycle
  // on the edge that loads c_flat/is_ident, and busy covers the MAC cycles.
  state_t           state;
  logic [N*N*W-1:0] a_mat, b_mat, c_work, c_next;
  logic [IW-1:0]    i, j, k, op_i, op_j;
  logic [W-1:0]     op_a, op_b, mac_sum;
  logic             issue_en, op_valid, op_last, ident_trk;
  logic             accept, wr, last_wr, ident_ok;

  assign accept    = (state == IDLE || state == DONE) && start;
  assign wr        = op_valid && op_last;
  assign last_wr   = wr && (op_i == LAST) && (op_j == LAST);
  assign ident_ok  = (mac_sum == ((op_i == op_j) ? W'(1) : W'(0)));
  assign dbg_state = state;

  always_comb begin
    c_next = c_work;
    if (wr) c_next[flat_off(int'(op_i), int'(op_j), N, W) +: W] = mac_sum;
  end

  mac_unit #(.W(W)) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept || wr),
    .en    (op_valid && !op_last),
    .a     (op_a),
    .b     (op_b),
    .sum   (mac_sum)
  );

  // Operands are fetched one cycle ahead of the MAC so the element mux and the
  // multiplier sit in separate cycles; this is the extra cycle before busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0; done <= 1'b0; is_ident <= 1'b0; c_flat <= '0;
      a_mat <= '0; b_mat <= '0; c_work <= '0;
      i <= '0; j <= '0; k <= '0; op_i <= '0; op_j <= '0;
      op_a <= '0; op_b <= '0;
      issue_en <= 1'b0; op_valid <= 1'b0; op_last <= 1'b0; ident_trk <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_mat <= a_flat; b_mat <= b_flat;
            i <= '0; j <= '0; k <= '0;
            ident_trk <= 1'b1;
            issue_en <= 1'b1;
            op_valid <= 1'b0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          op_valid <= issue_en;
          if (issue_en) begin
            op_a    <= a_mat[flat_off(int'(i), int'(k), N, W) +: W];
            op_b    <= b_mat[flat_off(int'(k), int'(j), N, W) +: W];
            op_last <= (k == LAST);
            op_i    <= i;
            op_j    <= j;
            busy    <= 1'b1;
            if (k == LAST) begin
              k <= '0;
              if (j == LAST) begin
                j <= '0;
                if (i == LAST) issue_en <= 1'b0;
                else i <= i + 1'b1;
              end else begin
                j <= j + 1'b1;
              end
            end else begin
              k <= k + 1'b1;
            end
          end
          if (wr) begin
            c_work <= c_next;
            if (!ident_ok) ident_trk <= 1'b0;
          end
          if (last_wr) begin
            state    <= DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            c_flat   <= c_next;
            is_ident <= ident_trk && ident_ok;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mat_mult_seq.sv
// Directed bench for mat_mult_seq: a plain-arithmetic matrix model drives a
// per-cycle compare of busy/done/c_flat/is_ident, plus literal spot checks.
module tb_mat_mult_seq;
  localparam int N   = 5;
  localparam int W   = 32;
  localparam int NNW = N * N * W;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [NNW-1:0] a_flat = '0;
  logic [NNW-1:0] b_flat = '0;
  logic           busy, done, is_ident;
  logic [NNW-1:0] c_flat;
  logic [1:0]     dbg_state;

  int errors = 0;
  int checks = 0;
  int n_done = 0;

  mat_mult_seq #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a_flat    (a_flat),
    .b_flat    (b_flat),
    .busy      (busy),
    .done      (done),
    .c_flat    (c_flat),
    .is_ident  (is_ident),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- matrix helpers ----------------
  function automatic logic [NNW-1:0] mk(input logic [W-1:0] d, input logic [W-1:0] sup,
                                        input logic [W-1:0] up, input logic [W-1:0] lo);
    logic [NNW-1:0] m;
    m = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m[(r*N+c)*W +: W] = (r == c) ? d : (c == r + 1) ? sup : (c > r) ? up : lo;
    return m;
  endfunction

  function automatic logic [W-1:0] el(input logic [NNW-1:0] m, input int r, input int c);
    return m[(r*N+c)*W +: W];
  endfunction

  function automatic logic [NNW-1:0] model_mul(input logic [NNW-1:0] a, input logic [NNW-1:0] b);
    logic [NNW-1:0] p;
    logic [W-1:0]   s;
    p = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        s = '0;
        for (int q = 0; q < N; q++) s = s + el(a, r, q) * el(b, q, c);
        p[(r*N+c)*W +: W] = s;
      end
    return p;
  endfunction

  // ---------------- scoreboard ----------------
  logic [NNW-1:0] exp_q[$];
  logic [NNW-1:0] m_c = '0;
  logic           m_id = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_active = 1'b0;
  int             m_cnt = 0;

  task automatic chk(input string name, input logic [NNW-1:0] act, input logic [NNW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: an accepted start yields its product 126 edges later; busy covers
  // the 125 edges in between; reset drops everything.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_id = 1'b0; m_c = '0;
      m_cnt = 0; exp_q.delete();
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        m_cnt++;
        m_busy = (m_cnt < 126);
        if (m_cnt == 126) begin
          m_active = 1'b0;
          m_done = 1'b1;
          m_c = exp_q.pop_front();
          m_id = (m_c == mk(1, 0, 0, 0));
        end
      end else if (start) begin
        m_active = 1'b1;
        m_cnt = 0;
        exp_q.push_back(model_mul(a_flat, b_flat));
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("is_ident", is_ident, m_id);
    chk("c_flat", c_flat, m_c);
    if (done) n_done++;
  end

  // ---------------- driver tasks ----------------
  task automatic scramble_inputs();
    for (int e = 0; e < N * N; e++) begin
      a_flat[e*W +: W] = $urandom();
      b_flat[e*W +: W] = $urandom();
    end
  endtask

  // Called on the negedge right after the accepting edge.
  task automatic wait_done(input int repulse_at, output int lat, output int bcnt);
    lat = 0;
    bcnt = int'(busy);
    while (!done && lat < 300) begin
      if (lat == repulse_at) begin
        start = 1'b1; a_flat = mk(1, 0, 0, 0); b_flat = mk(1, 0, 0, 0);
      end else if (repulse_at >= 0) begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
    start = (repulse_at >= 0) ? 1'b0 : start;
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic do_run(input logic [NNW-1:0] a, input logic [NNW-1:0] b, input int repulse_at,
                        output int lat, output int bcnt);
    @(negedge clk);
    a_flat = a; b_flat = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble_inputs();
    wait_done(repulse_at, lat, bcnt);
  endtask

  // ---------------- directed sequence ----------------
  logic [NNW-1:0] ident, up1, bid;
  int lat, bcnt, nd0;

  initial begin
    ident = mk(1, 0, 0, 0);
    up1   = mk(1, 1, 1, 0);
    bid   = mk(1, 32'hFFFF_FFFF, 0, 0);

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_is_ident", is_ident, 0);
    chk("rst_c_flat", c_flat, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // identity x identity
    do_run(ident, ident, -1, lat, bcnt);
    chk("ixi_latency", lat, 126);
    chk("ixi_busy_cycles", bcnt, 125);
    chk("ixi_is_ident", is_ident, 1);
    chk("ixi_c00", el(c_flat, 0, 0), 32'd1);
    chk("ixi_c01", el(c_flat, 0, 1), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);

    // diagonal scaling
    do_run(mk(2, 0, 0, 0), mk(3, 0, 0, 0), -1, lat, bcnt);
    chk("diag_c00", el(c_flat, 0, 0), 32'd6);
    chk("diag_c44", el(c_flat, 4, 4), 32'd6);
    chk("diag_c12", el(c_flat, 1, 2), 32'd0);
    chk("diag_is_ident", is_ident, 0);

    // start re-pulsed mid-run with other inputs is ignored
    do_run(mk(2, 0, 0, 0), mk(3, 0, 0, 0), 50, lat, bcnt);
    chk("repulse_latency", lat, 126);
    chk("repulse_c22", el(c_flat, 2, 2), 32'd6);
    chk("repulse_is_ident", is_ident, 0);

    // products of 2^16 * 2^16 wrap to zero
    do_run(mk(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000),
           mk(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000), -1, lat, bcnt);
    chk("wrap_c00", el(c_flat, 0, 0), 32'd0);
    chk("wrap_c34", el(c_flat, 3, 4), 32'd0);

    // all-ones times identity reproduces A
    do_run(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF), ident, -1, lat, bcnt);
    chk("ones_c23", el(c_flat, 2, 3), 32'hFFFF_FFFF);
    chk("ones_c40", el(c_flat, 4, 0), 32'hFFFF_FFFF);
    chk("ones_is_ident", is_ident, 0);

    // inverse pair, then start held through DONE with the operands swapped
    @(negedge clk);
    a_flat = up1; b_flat = bid; start = 1'b1;
    @(negedge clk);
    wait_done(-1, lat, bcnt);
    chk("inv_latency", lat, 126);
    chk("inv_is_ident", is_ident, 1);
    chk("inv_c01", el(c_flat, 0, 1), 32'd0);
    a_flat = bid; b_flat = up1;
    @(negedge clk);
    start = 1'b0;
    scramble_inputs();
    wait_done(-1, lat, bcnt);
    chk("b2b_latency", lat, 126);
    chk("swap_is_ident", is_ident, 1);
    chk("swap_c33", el(c_flat, 3, 3), 32'd1);
    chk("swap_c34", el(c_flat, 3, 4), 32'd0);

    // asynchronous reset in the middle of a run
    @(negedge clk);
    a_flat = ident; b_flat = ident; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    chk("mid_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_is_ident", is_ident, 0);
    chk("arst_c_flat", c_flat, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd0 = n_done;
    repeat (20) @(negedge clk);
    chk("no_done_after_reset", n_done, nd0);

    // fresh run after reset
    do_run(mk(2, 0, 0, 0), mk(3, 0, 0, 0), -1, lat, bcnt);
    chk("post_rst_latency", lat, 126);
    chk("post_rst_c11", el(c_flat, 1, 1), 32'd6);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
